serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be at least 2.
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; SHALL be at least 1 and divide WIDTH exactly.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port start  input  1: request to begin an operation; sampled only in IDLE.
REQ-006 Port a  input  WIDTH: operand A; sampled on the accepted start.
REQ-007 Port b  input  WIDTH: operand B; sampled on the accepted start.
REQ-008 Port cin  input  1: carry-in for add mode; sampled on the accepted start.
REQ-009 Port sub  input  1: mode, 0 = add, 1 = subtract; sampled on the accepted start.
REQ-010 Port busy  output  1: high while in RUN.
REQ-011 Port done  output  1: one-cycle pulse; sum, cout and ovf are valid from this cycle onward.
REQ-012 Port sum  output  WIDTH: result.
REQ-013 Port cout  output  1: final carry-out (add) or NOT-borrow (subtract).
REQ-014 Port ovf  output  1: two's-complement signed overflow.

Function
REQ-015 States SHALL be IDLE, RUN and DONE.
REQ-016 Transitions: IDLE->RUN on start=1; RUN->DONE after N=WIDTH/DIGIT RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-017 On an accepted start:
- a is latched;
- b is latched as b when sub=0, or ~b when sub=1;
- the carry register is loaded with cin when sub=0, or with 1 when sub=1 (cin is ignored in subtract mode);
- the digit counter is cleared.
REQ-018 Each RUN cycle SHALL:
- add the DIGIT-bit slice at the counter position through a ripple chain of DIGIT full-adder cells, seeded from the carry register;
- write the slice result into sum;
- store the chain carry-out in the carry register;
- increment the counter.
REQ-019 Slices SHALL be processed LSB first.
REQ-020 After the last slice:
- cout SHALL equal the final carry;
- ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-021 Latency: done SHALL be high in the cycle that follows exactly N+1 rising edges after the edge that sampled start.
REQ-022 busy SHALL be high for exactly N cycles per operation; done and busy SHALL never both be high.
REQ-023 start while in RUN or DONE SHALL be ignored; operand and mode inputs SHALL then have no effect.
REQ-024 sum, cout and ovf SHALL hold their values from DONE until the next accepted start.
REQ-025 sum MAY change during RUN; consumers SHALL use it only from done onward.
REQ-026 Holding start high continuously SHALL produce back-to-back operations separated by exactly one IDLE cycle.
REQ-027 The counter SHALL wrap to 0 on entry to DONE; there SHALL be no out-of-range slice access.

Reset
REQ-028 rst=1 SHALL, on the next rising edge, force IDLE and clear to 0: busy, done, sum, cout, ovf, the carry register, the counter and the operand registers.
REQ-029 Reset mid-RUN SHALL abort the operation; done SHALL NOT be pulsed for the aborted operation.
REQ-030 rst SHALL take priority over start in the same cycle.

Structure
REQ-031 A shared package SHALL hold:
- the state enumeration (IDLE, RUN, DONE);
- a localparam function computing the counter width as clog2(WIDTH/DIGIT), minimum 1.
REQ-032 One sub-module fa_cell SHALL implement a combinational 1-bit full adder with inputs a, b, cin and outputs s, co.
REQ-033 fa_cell SHALL compute s = a^b^cin and co = majority(a, b, cin).
REQ-034 fa_cell SHALL be instantiated DIGIT times in a generate loop.
REQ-035 The block SHALL contain no other sub-modules.
REQ-036 Parameter legality (REQ-001, REQ-002) SHALL be checked at elaboration.

Verification
REQ-037 WIDTH=8, DIGIT=1, add, 0x0F+0x01, cin=0 -> sum 0x10, cout 0, ovf 0; done exactly 9 edges after start; busy high 8 cycles.
REQ-038 WIDTH=8, DIGIT=1, add, 0x7F+0x01 -> sum 0x80, ovf 1, cout 0; 0xFF+0x01 -> sum 0x00, cout 1, ovf 0.
REQ-039 WIDTH=8, DIGIT=1, sub=1, 0x05-0x07, cin=1 -> sum 0xFE, cout 0, ovf 0 (cin ignored); 0x80-0x01 -> sum 0x7F, cout 1, ovf 1.
REQ-040 WIDTH=8, DIGIT=4, add, 0x10+0x20, cin=1 -> sum 0x31; done 3 edges after start; busy high 2 cycles.
REQ-041 Second start pulsed mid-RUN with different operands -> ignored; the first result is delivered unchanged; start held high -> one IDLE cycle between done and the next busy.
REQ-042 rst asserted at RUN cycle 4 -> next cycle IDLE with all outputs 0 and no done pulse; a fresh 0x03+0x04 -> sum 0x07.
REQ-043 All eight 1-bit combinations of a, b, cin with WIDTH=2, DIGIT=1 (operands zero-extended) -> sum and cout match the full-adder truth table.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the digit counter: clog2 of the slice count, never below one bit.
  function automatic int cnt_width(input int width, input int digit);
    int w;
    w = $clog2(width / digit);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the digit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; one link of the per-cycle ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB slice first.
// Subtraction is a + ~b + 1, so cout reads as NOT-borrow in that mode.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2) begin : g_chk_width
    $error("serial_adder: WIDTH must be at least 2");
  end
  if (DIGIT < 1) begin : g_chk_digit
    $error("serial_adder: DIGIT must be at least 1");
  end else if ((WIDTH % DIGIT) != 0) begin : g_chk_div
    $error("serial_adder: DIGIT must divide WIDTH");
  end

  state_t           state, nxt;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry, cout_r, ovf_r;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] sl_a, sl_b, sl_s;
  logic [DIGIT:0]   ch;
  int               idx;

  // Current slice position; cnt never exceeds N-1, so the select stays in range.
  assign idx   = int'(cnt) * DIGIT;
  assign sl_a  = a_r[idx +: DIGIT];
  assign sl_b  = b_r[idx +: DIGIT];
  assign ch[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fa_cell u_fa (
      .a   (sl_a[i]),
      .b   (sl_b[i]),
      .cin (ch[i]),
      .s   (sl_s[i]),
      .co  (ch[i+1])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state and status decode.
  always_comb begin
    nxt      = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE: if (bus.start) nxt = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (cnt == LAST) nxt = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        nxt      = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Operand capture on accepted start, then one slice per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE && bus.start) begin
      a_r   <= bus.a;
      b_r   <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub ? 1'b1 : bus.cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum_r[idx +: DIGIT] <= sl_s;
      carry               <= ch[DIGIT];
      if (cnt == LAST) begin
        cnt    <= '0;
        cout_r <= ch[DIGIT];
        // Carry into the MSB cell vs. carry out of it.
        ovf_r  <= ch[DIGIT-1] ^ ch[DIGIT];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three configurations (8/1, 8/4, 2/1).
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus1 ();
  serial_adder_if #(.WIDTH(8)) bus4 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(bus1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_adder #(.WIDTH(2), .DIGIT(1)) u_d2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub);
    if (sel == 0) begin
      bus1.start = st; bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub;
    end else begin
      bus4.start = st; bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = sub;
    end
  endtask

  task automatic peek(input int sel, output logic bs, output logic dn, output logic [7:0] sm,
                      output logic co, output logic ov);
    if (sel == 0) begin
      bs = bus1.busy; dn = bus1.done; sm = bus1.sum; co = bus1.cout; ov = bus1.ovf;
    end else begin
      bs = bus4.busy; dn = bus4.done; sm = bus4.sum; co = bus4.cout; ov = bus4.ovf;
    end
  endtask

  // Present a request for one cycle; returns just after the sampling edge.
  task automatic apply(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub);
    @(negedge clk);
    drive(sel, 1'b1, a, b, cin, sub);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, a, b, cin, sub);
  endtask

  // Edges counted from the sampling edge (which counts as 1) up to the done cycle.
  task automatic wait_done(input int sel, input string tag, output int edges, output int bcnt,
                           output int ovl);
    logic bs, dn, co, ov;
    logic [7:0] sm;
    int found;
    edges = 1; bcnt = 0; ovl = 0; found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      peek(sel, bs, dn, sm, co, ov);
      if (bs && dn) ovl++;
      if (dn) found = 1;
      else begin
        if (bs) bcnt++;
        @(posedge clk);
        edges++;
      end
    end
    check({tag, "_done_seen"}, found, 1);
  endtask

  task automatic check_res(input int sel, input string tag, input logic [7:0] es,
                           input logic ec, input logic eo);
    logic bs, dn, co, ov;
    logic [7:0] sm;
    peek(sel, bs, dn, sm, co, ov);
    check({tag, "_sum"}, sm, es);
    check({tag, "_cout"}, co, ec);
    check({tag, "_ovf"}, ov, eo);
  endtask

  initial begin
    int edges, bcnt, ovl, dpulse, found;
    logic bs, dn, co, ov;
    logic [7:0] sm;
    logic [1:0] pop [8];
    pop = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus2.start = 1'b0; bus2.a = 2'b00; bus2.b = 2'b00; bus2.cin = 1'b0; bus2.sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    peek(0, bs, dn, sm, co, ov);
    check("rst_busy", bs, 0);
    check("rst_done", dn, 0);
    check_res(0, "rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // 0x0F + 0x01: latency, busy length, result.
    apply(0, 8'h0F, 8'h01, 1'b0, 1'b0);
    wait_done(0, "add0f", edges, bcnt, ovl);
    check("add0f_edges", edges, 9);
    check("add0f_busy_cycles", bcnt, 8);
    check("add0f_overlap", ovl, 0);
    check_res(0, "add0f", 8'h10, 1'b0, 1'b0);
    drive(0, 1'b0, 8'hAA, 8'h55, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_res(0, "add0f_hold", 8'h10, 1'b0, 1'b0);

    apply(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(0, "add7f", edges, bcnt, ovl);
    check_res(0, "add7f", 8'h80, 1'b0, 1'b1);

    apply(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(0, "addff", edges, bcnt, ovl);
    check_res(0, "addff", 8'h00, 1'b1, 1'b0);

    apply(0, 8'h05, 8'h07, 1'b1, 1'b1);
    wait_done(0, "sub05", edges, bcnt, ovl);
    check_res(0, "sub05", 8'hFE, 1'b0, 1'b0);

    apply(0, 8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(0, "sub80", edges, bcnt, ovl);
    check_res(0, "sub80", 8'h7F, 1'b1, 1'b1);

    // Four bits per cycle.
    apply(1, 8'h10, 8'h20, 1'b1, 1'b0);
    wait_done(1, "d4", edges, bcnt, ovl);
    check("d4_edges", edges, 3);
    check("d4_busy_cycles", bcnt, 2);
    check("d4_overlap", ovl, 0);
    check_res(1, "d4", 8'h31, 1'b0, 1'b0);

    // A second request during RUN must be ignored.
    apply(0, 8'h0F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 8'hAA, 8'h55, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'hAA, 8'h55, 1'b1, 1'b1);
    wait_done(0, "midstart", edges, bcnt, ovl);
    check_res(0, "midstart", 8'h10, 1'b0, 1'b0);

    // start held high: exactly one idle cycle between done and next busy.
    @(negedge clk);
    drive(0, 1'b1, 8'h03, 8'h04, 1'b0, 1'b0);
    wait_done(0, "held1", edges, bcnt, ovl);
    check_res(0, "held1", 8'h07, 1'b0, 1'b0);
    @(negedge clk);
    peek(0, bs, dn, sm, co, ov);
    check("held_gap_busy", bs, 0);
    check("held_gap_done", dn, 0);
    @(negedge clk);
    peek(0, bs, dn, sm, co, ov);
    check("held_restart_busy", bs, 1);
    drive(0, 1'b0, 8'h03, 8'h04, 1'b0, 1'b0);
    wait_done(0, "held2", edges, bcnt, ovl);
    check_res(0, "held2", 8'h07, 1'b0, 1'b0);

    // Reset during RUN cycle 4 of 0xFF + 0x00 after a result with cout=ovf=1.
    apply(0, 8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(0, "pre_rst", edges, bcnt, ovl);
    check_res(0, "pre_rst", 8'h7F, 1'b1, 1'b1);
    apply(0, 8'hFF, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    peek(0, bs, dn, sm, co, ov);
    check("abort_busy", bs, 0);
    check("abort_done", dn, 0);
    check_res(0, "abort", 8'h00, 1'b0, 1'b0);
    dpulse = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      peek(0, bs, dn, sm, co, ov);
      if (dn || bs) dpulse++;
    end
    check("abort_no_done", dpulse, 0);
    apply(0, 8'h03, 8'h04, 1'b0, 1'b0);
    wait_done(0, "post_rst", edges, bcnt, ovl);
    check_res(0, "post_rst", 8'h07, 1'b0, 1'b0);

    // Full-adder truth table on the 2-bit instance; result equals the count of ones.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus2.a = {1'b0, i[2]};
      bus2.b = {1'b0, i[1]};
      bus2.cin = i[0];
      bus2.start = 1'b1;
      @(posedge clk);
      #1 bus2.start = 1'b0;
      found = 0;
      for (int k = 0; k < 10 && found == 0; k++) begin
        @(negedge clk);
        if (bus2.done) found = 1;
      end
      check($sformatf("fa%0d_done_seen", i), found, 1);
      check($sformatf("fa%0d_sum", i), bus2.sum, pop[i]);
      check($sformatf("fa%0d_cout", i), bus2.cout, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
